// File: rtl/dp_ram16k_fifo_ctrl.sv
// rtl/dp_ram16k_fifo_ctrl.sv - show-ahead FIFO controller driving a DP_RAM16K (512x32) macro
// Define QLF_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module dp_ram16k_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int AF_TH  = 504,
  parameter int AE_TH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [DATA_W-1:0] ram_wenb,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_d_out
`ifdef QLF_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  cnt_t              ram_cnt_q, ram_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              push_acc, pop_acc, rd_issue;

  // The RAM read register doubles as the head slot, so a read is issued
  // whenever that slot is free or being vacated this cycle.
  always_comb begin
    push_acc    = push & ~full & ~rst;
    pop_acc     = pop & out_valid_q & ~rst;
    rd_issue    = ~rst & (ram_cnt_q != '0) & (~out_valid_q | pop_acc);
    wptr_d      = wptr_q + ADDR_W'(push_acc);
    rptr_d      = rptr_q + ADDR_W'(rd_issue);
    ram_cnt_d   = ram_cnt_q + cnt_t'(push_acc) - cnt_t'(rd_issue);
    out_valid_d = rd_issue | (out_valid_q & ~pop_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign full         = (ram_cnt_q == DEPTH_C);
  assign empty        = ~out_valid_q;
  assign count        = ram_cnt_q + cnt_t'(out_valid_q);
  assign almost_full  = (count >= cnt_t'(AF_TH));
  assign almost_empty = (count <= cnt_t'(AE_TH));
  assign pop_data     = ram_d_out;

  assign ram_wen   = ~push_acc;
  assign ram_waddr = wptr_q;
  assign ram_d_in  = push_data;
  assign ram_wenb  = '1;
  assign ram_ren   = ~rd_issue;
  assign ram_raddr = rptr_q;

`ifdef QLF_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_dp_ram16k_fifo_ctrl.sv
// tb/tb_dp_ram16k_fifo_ctrl.sv - self-checking bench with RAM model and queue-based FIFO reference
module tb_dp_ram16k_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst, push, pop;
  logic [31:0] push_data, pop_data, ram_d_in, ram_wenb, ram_d_out;
  logic        full, empty, almost_full, almost_empty, ram_wen, ram_ren;
  logic [9:0]  count;
  logic [8:0]  ram_waddr, ram_raddr;
`ifdef QLF_FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif

  dp_ram16k_fifo_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .full(full), .empty(empty), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_d_in(ram_d_in),
    .ram_wenb(ram_wenb), .ram_ren(ram_ren), .ram_raddr(ram_raddr),
    .ram_d_out(ram_d_out)
`ifdef QLF_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // DP_RAM16K behavioural model: masked write, registered read
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (!ram_wen) mem[ram_waddr] <= (mem[ram_waddr] & ~ram_wenb) | (ram_d_in & ram_wenb);
    if (!ram_ren) ram_d_out <= mem[ram_raddr];
  end

  // Reference: each held word carries the first cycle it may be the head
  typedef struct { logic [31:0] data; int avail; } ent_t;
  ent_t        mq[$];
  int          cyc = 0, wr_total = 0, pops = 0, total = 0, bad = 0;
  logic [31:0] last_pop;
  logic        m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    logic push; logic [31:0] data; logic pop;
    logic e_empty; logic [9:0] e_count; logic [31:0] e_data;
  } vec_t;
  vec_t tbl [11];

  function automatic bit m_vis();
    return (mq.size() > 0) && (mq[0].avail <= cyc);
  endfunction

  function automatic bit m_full();
    return (mq.size() - (m_vis() ? 1 : 0)) == 512;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic p, input logic [31:0] d, input logic q);
    bit v, f, acc;
    push = p; push_data = d; pop = q;
    #1;
    v = m_vis(); f = m_full(); acc = p && !f;
    chk("empty", {31'd0, empty}, {31'd0, !v});
    chk("count", {22'd0, count}, mq.size());
    chk("full", {31'd0, full}, {31'd0, f});
    chk("almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= 504});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, mq.size() <= 4});
    chk("ram_wen", {31'd0, ram_wen}, {31'd0, !acc});
    if (acc) begin
      chk("ram_waddr", {23'd0, ram_waddr}, wr_total % 512);
      chk("ram_d_in", ram_d_in, d);
    end
    if (v) chk("pop_data", pop_data, mq[0].data);
`ifdef QLF_FIFO_ERR_FLAGS_EN
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
`endif
    if (p && f) m_ovf = 1'b1;
    if (q && !v) m_unf = 1'b1;
    if (q && v) begin
      last_pop = mq[0].data;
      pops++;
      void'(mq.pop_front());
      if (mq.size() > 0 && mq[0].avail < cyc + 1) mq[0].avail = cyc + 1;
    end
    if (acc) begin
      mq.push_back('{data: d, avail: cyc + 2});
      wr_total++;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = $urandom;
    #1;
    chk("rst_ram_wen", {31'd0, ram_wen}, 32'd1);
    chk("rst_ram_ren", {31'd0, ram_ren}, 32'd1);
    @(posedge clk); #1; cyc++;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    mq.delete(); wr_total = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 10'd0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 10'd1, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 10'd1, 32'hA5A5_0001};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 10'd1, 32'hA5A5_0001};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 10'd0, 32'h0};
    tbl[5]  = '{1'b1, 32'h2,         1'b0, 1'b1, 10'd0, 32'h0};
    tbl[6]  = '{1'b1, 32'h3,         1'b0, 1'b1, 10'd1, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 10'd2, 32'h2};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 10'd2, 32'h2};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 10'd1, 32'h3};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 10'd0, 32'h0};

    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    @(posedge clk); #1;
    do_reset();
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_count", {22'd0, count}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_af", {31'd0, almost_full}, 32'd0);
    chk("reset_ae", {31'd0, almost_empty}, 32'd1);
    chk("reset_wenb", ram_wenb, 32'hFFFF_FFFF);

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
      chk($sformatf("tbl%0d_count", i), {22'd0, count}, {22'd0, tbl[i].e_count});
      if (!tbl[i].e_empty) chk($sformatf("tbl%0d_data", i), pop_data, tbl[i].e_data);
      step(tbl[i].push, tbl[i].data, tbl[i].pop);
    end

    // Fill past capacity, then drain
    do_reset();
    for (int i = 0; i < 514; i++) begin
      if (i == 503) chk("af_at_503", {31'd0, almost_full}, 32'd0);
      if (i == 504) chk("af_at_504", {31'd0, almost_full}, 32'd1);
      step(1'b1, i, 1'b0);
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {22'd0, count}, 32'd513);
    chk("fill_head", pop_data, 32'd0);
`ifdef QLF_FIFO_ERR_FLAGS_EN
    chk("fill_overflow", {31'd0, overflow}, 32'd1);
`endif
    pops = 0;
    for (int j = 0; j < 520; j++) begin
      if (j == 508) chk("ae_at_5", {31'd0, almost_empty}, 32'd0);
      if (j == 509) chk("ae_at_4", {31'd0, almost_empty}, 32'd1);
      step(1'b0, 32'd0, 1'b1);
    end
    chk("drain_pops", pops, 32'd513);
    chk("drain_last", last_pop, 32'd512);

    // Pops on an empty FIFO
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    chk("epop_count", {22'd0, count}, 32'd0);
    chk("epop_empty", {31'd0, empty}, 32'd1);
`ifdef QLF_FIFO_ERR_FLAGS_EN
    chk("epop_underflow", {31'd0, underflow}, 32'd1);
`endif

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 510; i++) step(1'b1, 32'h5000 + i, 1'b0);
    do_reset();
    #1;
    chk("mrst_empty", {31'd0, empty}, 32'd1);
    chk("mrst_count", {22'd0, count}, 32'd0);
    chk("mrst_wen", {31'd0, ram_wen}, 32'd1);
    chk("mrst_ren", {31'd0, ram_ren}, 32'd1);
    step(1'b1, 32'h1234, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    chk("mrst_head", pop_data, 32'h1234);
    step(1'b0, 32'd0, 1'b1);
    chk("mrst_popped", last_pop, 32'h1234);

    // Sustained push+pop, pointers wrap
    do_reset();
    pops = 0;
    for (int i = 0; i < 1000; i++) step(1'b1, 32'h100 + i, m_vis());
    chk("stream_pops", pops, 32'd998);
    chk("stream_last", last_pop, 32'h100 + 997);

    // Random traffic with alternating fill/drain bias
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int pb, qb;
      pb = ((i / 700) % 2 == 0) ? 92 : 25;
      qb = ((i / 700) % 2 == 0) ? 20 : 90;
      step($urandom_range(0, 99) < pb, $urandom, $urandom_range(0, 99) < qb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_ram16k_fifo_ctrl.md
# dp_ram16k_fifo_ctrl

Single-clock, first-word-fall-through FIFO controller that drives one DP_RAM16K macro (512 x 32) as its storage array. It sits directly upstream of the RAM: it generates the RAM write and read ports from a push/pop handshake and uses the RAM's registered read output as the FIFO head. Status outputs (full, empty, count, almost flags) are derived only from registered state.

## Interface
- ADDR_W, 9: RAM address width; RAM depth DEPTH = 2^ADDR_W.
- DATA_W, 32: data width; must match the RAM.
- AF_TH, 504: almost_full asserts when count >= AF_TH.
- AE_TH, 4: almost_empty asserts when count <= AE_TH.

Ports:
- clk  in  1  single clock; also drives RAM wclk and rclk.
- rst  in  1  reset, synchronous, active-high.
- push  in  1  write request.
- push_data  in  DATA_W  write data.
- pop  in  1  consume the head word.
- pop_data  out  DATA_W  head word; wired from ram_d_out; valid while empty=0.
- full  out  1  RAM holds DEPTH unread words.
- empty  out  1  no valid head word.
- count  out  ADDR_W+1  total words held, 0..DEPTH+1.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- ram_wen  out  1  RAM write enable, active-low.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_d_in  out  DATA_W  equals push_data.
- ram_wenb  out  DATA_W  write bit mask; constant all-ones.
- ram_ren  out  1  RAM read enable, active-low.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_d_out  in  DATA_W  RAM registered read data.

## Operation
- State: wptr, rptr (ADDR_W each, wrap modulo DEPTH); ram_cnt (0..DEPTH); out_valid (1 bit, meaning ram_d_out holds an unconsumed word).
- push_acc = push & ~full. When push_acc = 1: ram_wen = 0, ram_waddr = wptr, and wptr increments. A push while full is dropped.
- pop_acc = pop & out_valid. A pop while empty is ignored.
- rd_issue = (ram_cnt != 0) & (~out_valid | pop_acc). When rd_issue = 1: ram_ren = 0, ram_raddr = rptr, and rptr increments.
- Next-state rules:
  - ram_cnt <= ram_cnt + push_acc - rd_issue.
  - out_valid <= rd_issue | (out_valid & ~pop_acc).
- Derived outputs:
  - empty = ~out_valid.
  - full = (ram_cnt == DEPTH).
  - count = ram_cnt + out_valid. Maximum is DEPTH+1 because the head word has already left its RAM slot.
- ram_wen and ram_ren are combinational from push/pop and registered state. All status outputs depend on registered state only.
- Pointer wrap: incrementing from DEPTH-1 wraps to 0. There is no special case at wrap.
- Simultaneous push and pop are both honoured in the same cycle. Push-acceptance is decided on the current full flag, so a pop in the same cycle does not allow a push while full.
- Reset values:
  - Registers: wptr = 0, rptr = 0, ram_cnt = 0, out_valid = 0.
  - Outputs: full = 0, empty = 1, count = 0, almost_full = 0, almost_empty = 1.
  - RAM controls: ram_wen = 1, ram_ren = 1 (both forced inactive while rst = 1, regardless of push/pop).
- Reset mid-operation discards all stored words. RAM contents are not cleared. pop_data is don't-care while empty = 1.

## Timing
- Write latency: a word pushed in cycle N is written at the end of N. It is read at the earliest in N+1 and is at pop_data with empty = 0 in N+2.
- pop_data is presented show-ahead: the head word is visible before pop. pop in cycle N consumes it, and the next word is at pop_data in N+1 if it was available in the RAM.
- Throughput is one push and one pop per cycle, sustained, with no bubbles once the FIFO is primed.
- full, count and the almost flags update one cycle after the causing push or pop.

## Configuration
- QLF_FIFO_ERR_FLAGS_EN defined:
  - Adds the outputs overflow and underflow, 1 bit each, both sticky.
  - overflow sets on push & full. underflow sets on pop & empty.
  - Both clear only on rst; reset value is 0.
- Undefined: the overflow and underflow ports do not exist, and illegal pushes and pops are silently ignored.

## Test plan
- Reset, then push 0xA5A5_0001 in cycle 0 -> empty = 0 and pop_data = 0xA5A5_0001 in cycle 2; count = 1.
- Push 513 words 0..512 with no pops -> full = 1 after the 513th word is accepted (512 in RAM plus the head); the 514th push is dropped; count = 513; overflow = 1 if enabled.
- Continuous push and pop every cycle for 1000 cycles -> pop_data increments by 1 each cycle with no gaps; the pointers wrap past 511 without error.
- Pop when empty after reset -> nothing changes and count stays 0; underflow = 1 if enabled.
- Fill to 510, assert rst for one cycle mid-stream -> next cycle empty = 1, count = 0, ram_wen = 1 and ram_ren = 1; a following push of 0x1234 is popped as 0x1234.
- With AF_TH = 504 and AE_TH = 4: count 503 -> 504 asserts almost_full; count 5 -> 4 asserts almost_empty.
